// File: rtl/step_pulse_sequencer_if.sv
// step_pulse_sequencer_if: Avalon-MM register bus plus step/dir driver outputs
interface step_pulse_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        step_out;
  logic        dir_out;
  logic        irq;
  modport master(output address, chipselect, write_n, writedata, input readdata, step_out, dir_out, irq);
  modport slave(input address, chipselect, write_n, writedata, output readdata, step_out, dir_out, irq);
endinterface

// File: rtl/step_pulse_sequencer.sv
// step_pulse_sequencer: register-programmed step/dir pulse train generator
module step_pulse_sequencer #(
  parameter int SETUP_CYC = 50,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset_n,
  step_pulse_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  state_t state;
  logic [CNT_W-1:0] period, steps, remain, cnt, half_len, low_len, lim, eff;
  logic done, irq_en, dir, busy, wr, ctrl_wr, start, stop, last, fin, done_nx, irq_en_nx;
  assign busy = state != IDLE;
  assign wr = bus.chipselect && !bus.write_n;
  assign ctrl_wr = wr && bus.address == 2'd0;
  assign start = ctrl_wr && bus.writedata[0] && !bus.writedata[1] && !busy;
  assign stop = ctrl_wr && bus.writedata[1] && busy;
  assign eff = period < CNT_W'(2) ? CNT_W'(2) : period;
  assign lim = state == SETUP ? CNT_W'(SETUP_CYC) : state == HIGH ? half_len : low_len;
  assign last = cnt + CNT_W'(1) >= lim;
  // a move finishes on stop, or when SETUP/LOW expires with nothing left to issue
  assign fin = stop || (last && remain == '0 && (state == SETUP || state == LOW));
  assign done_nx = fin ? 1'b1 : start ? 1'b0 : (wr && bus.address == 2'd3) ? 1'b0 : done;
  assign irq_en_nx = ctrl_wr ? bus.writedata[3] : irq_en;
  assign bus.readdata = bus.address == 2'd0 ? {28'd0, irq_en, dir, done, busy} :
                        bus.address == 2'd1 ? 32'(period) :
                        bus.address == 2'd2 ? 32'(steps) : 32'(remain);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      period <= '0;
      steps <= '0;
      remain <= '0;
      cnt <= '0;
      half_len <= '0;
      low_len <= '0;
      done <= 1'b0;
      irq_en <= 1'b0;
      dir <= 1'b0;
      bus.step_out <= 1'b0;
      bus.dir_out <= 1'b0;
      bus.irq <= 1'b0;
    end else begin
      done <= done_nx;
      irq_en <= irq_en_nx;
      bus.irq <= done_nx && irq_en_nx;
      if (wr && !busy && bus.address == 2'd1) period <= bus.writedata[CNT_W-1:0];
      if (wr && !busy && bus.address == 2'd2) steps <= bus.writedata[CNT_W-1:0];
      if (ctrl_wr && !busy) dir <= bus.writedata[2];
      if (state == IDLE) begin
        if (start) begin
          state <= SETUP;
          cnt <= '0;
          remain <= steps;
          bus.dir_out <= bus.writedata[2];
          half_len <= eff >> 1;
          low_len <= eff - (eff >> 1);
        end
      end else if (stop) begin
        state <= IDLE;
        bus.step_out <= 1'b0;
      end else if (!last) begin
        cnt <= cnt + CNT_W'(1);
      end else if (state == HIGH) begin
        cnt <= '0;
        state <= LOW;
        bus.step_out <= 1'b0;
        remain <= remain - CNT_W'(1);
      end else begin
        cnt <= '0;
        state <= remain == '0 ? IDLE : HIGH;
        bus.step_out <= remain != '0;
      end
    end
endmodule

// File: doc/step_pulse_sequencer.md
STEP_PULSE_SEQUENCER -- requirements
Module: step_pulse_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 50: clk cycles dir_out must be stable before the first step rising edge.
REQ-002 SHALL have parameter CNT_W, default 32: width of the PERIOD, STEPS and REMAIN counters.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 address  in  2  Avalon-MM register select.
REQ-006 chipselect  in  1  slave select.
REQ-007 write_n  in  1  active-low write strobe; write occurs when chipselect && !write_n.
REQ-008 writedata  in  32  write data.
REQ-009 readdata  out  32  combinational read data, zero wait states; unused bits 0.
REQ-010 step_out  out  1  registered step pulse to the driver.
REQ-011 dir_out  out  1  registered direction to the driver.
REQ-012 irq  out  1  registered; equals done && irq_en.

Function
REQ-013 Register map: 0 CTRL/STATUS, 1 PERIOD, 2 STEPS, 3 REMAIN.
REQ-014 CTRL write: bit0 start, bit1 stop, bit2 dir, bit3 irq_en; start/stop are self-clearing pulses, never stored.
REQ-015 STATUS read: bit0 busy, bit1 done, bit2 dir, bit3 irq_en.
REQ-016 PERIOD, STEPS: read/write low CNT_W bits; REMAIN read returns steps still to issue; any write to address 3 clears done.
REQ-017 FSM states: IDLE, SETUP, HIGH, LOW; busy = (state != IDLE).
REQ-018 IDLE -> SETUP on start write; REMAIN loads STEPS, done clears, dir_out updates to the dir register, all on the cycle after the write.
REQ-019 SETUP holds SETUP_CYC cycles, then -> HIGH; STEPS=0 at start -> IDLE instead of HIGH, done set, no pulse.
REQ-020 Effective period P = max(PERIOD, 2); HIGH lasts floor(P/2) cycles, LOW lasts P - floor(P/2) cycles.
REQ-021 step_out = 1 exactly while in HIGH; REMAIN decrements by 1 on HIGH -> LOW.
REQ-022 LOW end: REMAIN != 0 -> HIGH; REMAIN == 0 -> IDLE with done set.
REQ-023 Stop write while busy: -> IDLE next cycle, step_out 0 next cycle, done set, REMAIN retains value.
REQ-024 Start and stop in the same write: stop wins; start ignored.
REQ-025 Start while busy ignored; writes to PERIOD, STEPS and dir while busy ignored; irq_en writable anytime.
REQ-026 PERIOD/STEPS are sampled only at start; done stays set until a clear write or the next start.

Reset
REQ-027 Asynchronous reset: state IDLE, step_out 0, dir_out 0, irq 0, done 0, irq_en 0, PERIOD 0, STEPS 0, REMAIN 0, all counters 0.
REQ-028 Reset mid-move: step_out 0 immediately; no further pulses after release until a new start.

Verification
REQ-029 SETUP_CYC=4, PERIOD=10, STEPS=3, dir=1, start -> dir_out=1 next cycle; 3 pulses each 5 high / 5 low; first rise 5 cycles after write; done=1; REMAIN=0.
REQ-030 PERIOD=1, STEPS=2 -> pulses 1 high / 1 low (P=2); PERIOD=7 -> 3 high / 4 low.
REQ-031 STEPS=0, irq_en=1, start -> no pulse; done=1 and irq=1 after SETUP; write address 3 -> irq=0 next cycle.
REQ-032 STEPS=100, stop after 10 pulses -> step_out 0 next cycle; busy 0; done 1; REMAIN=90; restart reissues STEPS.
REQ-033 While busy: write STEPS=5, dir=0, start -> ignored; current move completes unchanged; STEPS read-back unchanged; CTRL start+stop together -> no move.
REQ-034 Assert reset_n low during HIGH -> step_out 0 asynchronously; all registers at reset values; no pulse after release.
